lms_input_frontend: RTL and testbench

// - Upstream stage of the LMS canceller. Takes two free-running ADC streams:

---
 rtl/lms_frontend_pkg.sv | 26 ++
 rtl/lms_input_frontend_if.sv | 29 ++
 rtl/lms_sample_fifo.sv | 44 ++++
 rtl/lms_input_frontend.sv | 133 +++++++++++++
 tb/tb_lms_input_frontend.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lms_frontend_pkg.sv
// Shared constants and helpers for the LMS input front end: default buffer depth,
// pointer-width calculation and signed saturation.
package lms_frontend_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Clamp a signed value to the range of a signed width-bit number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/lms_input_frontend_if.sv
// Bus between the ADC streams / LMS core and the input front end.
// Each ADC channel uses valid/ready: a sample transfers on a clock edge where both
// valid and ready are high; ready depends only on registered state, never on valid.
interface lms_input_frontend_if #(
    parameter int SIG_W = 12,
    parameter int NOS_W = 12
);
    logic [SIG_W-1:0] sig_raw;
    logic             sig_valid;
    logic             sig_ready;
    logic [NOS_W-1:0] nos_raw;
    logic             nos_valid;
    logic             nos_ready;
    logic             clr_desync;
    logic [SIG_W-1:0] signal;
    logic [NOS_W-1:0] noise;
    logic             out_valid;
    logic             desync;

    modport master (
        output sig_raw, sig_valid, nos_raw, nos_valid, clr_desync,
        input  sig_ready, nos_ready, signal, noise, out_valid, desync
    );

    modport slave (
        input  sig_raw, sig_valid, nos_raw, nos_valid, clr_desync,
        output sig_ready, nos_ready, signal, noise, out_valid, desync
    );
endinterface

// File: rtl/lms_sample_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers and a single-cycle flush.
// A flush empties the buffer and discards any push in the same cycle.
module lms_sample_fifo
    import lms_frontend_pkg::*;
#(
    parameter int W     = 12,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/lms_input_frontend.sv
// Front end of the LMS canceller: buffers primary/reference ADC streams, pairs them,
// converts to two's complement, optionally removes DC, saturates and holds the result.
`ifndef SIG_WIDTH
`define SIG_WIDTH 12
`endif
`ifndef NOS_WIDTH
`define NOS_WIDTH 12
`endif

module lms_input_frontend
    import lms_frontend_pkg::*;
#(
    parameter int SIG_W      = `SIG_WIDTH,
    parameter int NOS_W      = `NOS_WIDTH,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int OFFSET_BIN = 1,
    parameter int DC_EN      = 1,
    parameter int DC_SHIFT   = 10,
    parameter int TIMEOUT    = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    lms_input_frontend_if.slave bus
);
    localparam int CW    = clog2(TIMEOUT) + 1;
    localparam int S_ACW = SIG_W + DC_SHIFT + 1;
    localparam int N_ACW = NOS_W + DC_SHIFT + 1;

    logic             s_empty, s_full, n_empty, n_full;
    logic [SIG_W-1:0] s_dout;
    logic [NOS_W-1:0] n_dout;
    logic             push_s, push_n, pop, lone, flush_hit, flush_s, flush_n;
    logic [CW-1:0]    wait_cnt;
    logic             desync_q;

    // Ready is low throughout reset and otherwise reflects only the registered fill level.
    assign bus.sig_ready = rst_n && !s_full;
    assign bus.nos_ready = rst_n && !n_full;
    assign push_s        = bus.sig_valid && bus.sig_ready;
    assign push_n        = bus.nos_valid && bus.nos_ready;
    assign pop           = !s_empty && !n_empty;
    assign lone          = (s_empty != n_empty);
    assign flush_hit     = lone && (wait_cnt == CW'(TIMEOUT - 1));
    assign flush_s       = flush_hit && !s_empty;
    assign flush_n       = flush_hit && !n_empty;

    lms_sample_fifo #(.W(SIG_W), .DEPTH(FIFO_DEPTH)) u_sig_fifo (
        .clk(clk), .rst_n(rst_n), .push(push_s), .din(bus.sig_raw), .pop(pop),
        .flush(flush_s), .dout(s_dout), .empty(s_empty), .full(s_full)
    );

    lms_sample_fifo #(.W(NOS_W), .DEPTH(FIFO_DEPTH)) u_nos_fifo (
        .clk(clk), .rst_n(rst_n), .push(push_n), .din(bus.nos_raw), .pop(pop),
        .flush(flush_n), .dout(n_dout), .empty(n_empty), .full(n_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            desync_q <= 1'b0;
        end else begin
            if (flush_hit || !lone) wait_cnt <= '0;
            else                    wait_cnt <= wait_cnt + 1'b1;
            if (flush_hit)           desync_q <= 1'b1;
            else if (bus.clr_desync) desync_q <= 1'b0;
        end
    end

    // Stage 1: popped pair, converted to two's complement.
    logic signed [SIG_W-1:0] xs, pipe_xs;
    logic signed [NOS_W-1:0] xn, pipe_xn;
    logic                    pipe_v;

    always_comb begin
        xs = (OFFSET_BIN != 0) ? {~s_dout[SIG_W-1], s_dout[SIG_W-2:0]} : s_dout;
        xn = (OFFSET_BIN != 0) ? {~n_dout[NOS_W-1], n_dout[NOS_W-2:0]} : n_dout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v  <= 1'b0;
            pipe_xs <= '0;
            pipe_xn <= '0;
        end else begin
            pipe_v <= pop;
            if (pop) begin
                pipe_xs <= xs;
                pipe_xn <= xn;
            end
        end
    end

    // Stage 2: DC removal against the pre-update estimate, then saturation.
    logic signed [S_ACW-1:0] acc_s, dc_s;
    logic signed [N_ACW-1:0] acc_n, dc_n;
    logic signed [SIG_W:0]   diff_s;
    logic signed [NOS_W:0]   diff_n;
    logic signed [SIG_W-1:0] y_s, signal_q;
    logic signed [NOS_W-1:0] y_n, noise_q;
    logic                    out_valid_q;

    always_comb begin
        dc_s   = acc_s >>> DC_SHIFT;
        dc_n   = acc_n >>> DC_SHIFT;
        diff_s = {pipe_xs[SIG_W-1], pipe_xs} - dc_s[SIG_W:0];
        diff_n = {pipe_xn[NOS_W-1], pipe_xn} - dc_n[NOS_W:0];
        y_s    = (DC_EN != 0) ? SIG_W'(sat(32'(diff_s), SIG_W)) : pipe_xs;
        y_n    = (DC_EN != 0) ? NOS_W'(sat(32'(diff_n), NOS_W)) : pipe_xn;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_s       <= '0;
            acc_n       <= '0;
            signal_q    <= '0;
            noise_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= pipe_v;
            if (pipe_v) begin
                acc_s    <= acc_s + S_ACW'(pipe_xs) - dc_s;
                acc_n    <= acc_n + N_ACW'(pipe_xn) - dc_n;
                signal_q <= y_s;
                noise_q  <= y_n;
            end
        end
    end

    assign bus.signal    = signal_q;
    assign bus.noise     = noise_q;
    assign bus.out_valid = out_valid_q;
    assign bus.desync    = desync_q;
endmodule

// File: tb/tb_lms_input_frontend.sv
// Bench for lms_input_frontend: two instances (DC bypass and DC removal) share one
// stimulus stream and are compared every cycle against a queue-based reference model.
module tb_lms_input_frontend;
  import lms_frontend_pkg::*;

  localparam int W     = 12;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;
  localparam int SHIFT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] sig_raw = '0;
  logic [W-1:0] nos_raw = '0;
  logic         sig_valid = 1'b0;
  logic         nos_valid = 1'b0;
  logic         clr_desync = 1'b0;

  lms_input_frontend_if #(.SIG_W(W), .NOS_W(W)) bus0 ();
  lms_input_frontend_if #(.SIG_W(W), .NOS_W(W)) bus1 ();

  assign bus0.sig_raw = sig_raw;
  assign bus0.sig_valid = sig_valid;
  assign bus0.nos_raw = nos_raw;
  assign bus0.nos_valid = nos_valid;
  assign bus0.clr_desync = clr_desync;
  assign bus1.sig_raw = sig_raw;
  assign bus1.sig_valid = sig_valid;
  assign bus1.nos_raw = nos_raw;
  assign bus1.nos_valid = nos_valid;
  assign bus1.clr_desync = clr_desync;

  lms_input_frontend #(.SIG_W(W), .NOS_W(W), .FIFO_DEPTH(DEPTH), .OFFSET_BIN(1),
                       .DC_EN(0), .DC_SHIFT(SHIFT), .TIMEOUT(TMO))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  lms_input_frontend #(.SIG_W(W), .NOS_W(W), .FIFO_DEPTH(DEPTH), .OFFSET_BIN(1),
                       .DC_EN(1), .DC_SHIFT(SHIFT), .TIMEOUT(TMO))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // scoreboard state
  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0]   sq[$];
  logic [W-1:0]   nq[$];
  logic [2*W-1:0] exp_q[$];
  int             wait_cycles;
  longint         acc_s, acc_n;
  int             e_sig0, e_nos0, e_sig1, e_nos1;
  bit             e_ov, e_desync;

  logic [W-1:0] src_s[$];
  logic [W-1:0] src_n[$];
  bit           gate_s = 1'b0;
  bit           gate_n = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int conv(input logic [W-1:0] raw);
    return int'(raw) - (1 << (W - 1));
  endfunction

  function automatic int dc_apply(inout longint acc, input int x);
    longint dc;
    longint d;
    dc  = acc >>> SHIFT;
    d   = longint'(x) - dc;
    acc = acc + longint'(x) - dc;
    if (d > 2047) d = 2047;
    if (d < -2048) d = -2048;
    return int'(d);
  endfunction

  // Reference model: one call per rising edge, using the inputs held over that edge.
  task automatic model_step();
    bit s_ne, n_ne, ps, pn, lone, fl;
    logic [2*W-1:0] pr;
    int xs, xn;
    if (!rst_n) begin
      sq.delete(); nq.delete(); exp_q.delete();
      wait_cycles = 0; acc_s = 0; acc_n = 0;
      e_sig0 = 0; e_nos0 = 0; e_sig1 = 0; e_nos1 = 0; e_ov = 0; e_desync = 0;
      return;
    end
    s_ne = sq.size() > 0;
    n_ne = nq.size() > 0;
    ps   = sig_valid && (sq.size() < DEPTH);
    pn   = nos_valid && (nq.size() < DEPTH);
    lone = (s_ne != n_ne);
    fl   = lone && (wait_cycles == TMO - 1);
    e_ov = exp_q.size() > 0;
    if (e_ov) begin
      pr = exp_q.pop_front();
      xs = conv(pr[2*W-1:W]);
      xn = conv(pr[W-1:0]);
      e_sig0 = xs;
      e_nos0 = xn;
      e_sig1 = dc_apply(acc_s, xs);
      e_nos1 = dc_apply(acc_n, xn);
    end
    if (s_ne && n_ne) exp_q.push_back({sq.pop_front(), nq.pop_front()});
    if (fl) begin
      if (s_ne) begin sq.delete(); ps = 0; end
      else begin nq.delete(); pn = 0; end
    end
    if (ps) sq.push_back(sig_raw);
    if (pn) nq.push_back(nos_raw);
    wait_cycles = fl ? 0 : (lone ? wait_cycles + 1 : 0);
    if (fl) e_desync = 1;
    else if (clr_desync) e_desync = 0;
  endtask

  task automatic compare_all();
    int er_s, er_n;
    er_s = (rst_n && sq.size() < DEPTH) ? 1 : 0;
    er_n = (rst_n && nq.size() < DEPTH) ? 1 : 0;
    check("sig_ready", bus0.sig_ready, er_s);
    check("nos_ready", bus0.nos_ready, er_n);
    check("sig_ready_dc", bus1.sig_ready, er_s);
    check("out_valid", bus0.out_valid, e_ov);
    check("out_valid_dc", bus1.out_valid, e_ov);
    check("desync", bus0.desync, e_desync);
    check("desync_dc", bus1.desync, e_desync);
    check("signal", $signed(bus0.signal), e_sig0);
    check("noise", $signed(bus0.noise), e_nos0);
    check("signal_dc", $signed(bus1.signal), e_sig1);
    check("noise_dc", $signed(bus1.noise), e_nos1);
  endtask

  // driver: present source heads, clock one edge, retire accepted samples, check
  task automatic tick();
    bit acc_sf, acc_nf;
    sig_valid = (src_s.size() > 0) && gate_s;
    nos_valid = (src_n.size() > 0) && gate_n;
    if (sig_valid) sig_raw = src_s[0];
    if (nos_valid) nos_raw = src_n[0];
    @(posedge clk);
    acc_sf = sig_valid && rst_n && (sq.size() < DEPTH);
    acc_nf = nos_valid && rst_n && (nq.size() < DEPTH);
    model_step();
    if (acc_sf) void'(src_s.pop_front());
    if (acc_nf) void'(src_n.pop_front());
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    src_s.delete();
    src_n.delete();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    gate_s = 1; gate_n = 1;
    while ((src_s.size() + src_n.size() + sq.size() + nq.size() + exp_q.size()) > 0
           && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_bound", (n < max_cycles) ? 1 : 0, 1);
  endtask

  initial begin
    int run, max_run, prev, viol, first;
    bit seen;

    do_reset(3);

    // T1: single pair, latency and conversion
    src_s.push_back(12'hA00); src_n.push_back(12'h7FF);
    gate_s = 1; gate_n = 1;
    tick(); tick();
    check("t1_no_early_valid", bus0.out_valid, 0);
    tick();
    check("t1_valid", bus0.out_valid, 1);
    check("t1_signal", $signed(bus0.signal), 512);
    check("t1_noise", $signed(bus0.noise), -1);

    // T2: primary runs ahead until its buffer fills
    for (int i = 0; i < 5; i++) src_s.push_back(W'($urandom_range(0, 4095)));
    gate_n = 0;
    repeat (4) tick();
    check("t2_full_ready", bus0.sig_ready, 0);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) src_n.push_back(W'($urandom_range(0, 4095)));
    gate_n = 1;
    drain(40);

    // T3: 16 back-to-back pairs
    for (int i = 0; i < 16; i++) begin
      src_s.push_back(W'($urandom_range(0, 4095)));
      src_n.push_back(W'($urandom_range(0, 4095)));
    end
    run = 0; max_run = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      run = bus0.out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    check("t3_run_len", max_run, 16);

    // T4: DC decay on a constant input, then drive both saturation rails
    do_reset(2);
    for (int i = 0; i < 200; i++) begin
      src_s.push_back(12'h900); src_n.push_back(12'h900);
    end
    prev = 100000; viol = 0; seen = 0; first = 0;
    for (int i = 0; i < 210; i++) begin
      tick();
      if (bus1.out_valid) begin
        if (!seen) first = $signed(bus1.signal);
        seen = 1;
        if ($signed(bus1.signal) > prev) viol++;
        prev = $signed(bus1.signal);
      end
    end
    check("t4_first", first, 256);
    check("t4_monotonic_violations", viol, 0);
    check("t4_settled", (prev <= 16 && prev >= -16) ? 1 : 0, 1);
    src_s.push_back(12'h000); src_n.push_back(12'hFFF);
    tick(); tick(); tick();
    check("t4_neg_rail", $signed(bus1.signal), -2048);
    for (int i = 0; i < 60; i++) begin
      src_s.push_back(12'h000); src_n.push_back(W'($urandom_range(0, 4095)));
    end
    for (int i = 0; i < 4; i++) begin
      src_s.push_back(12'hFFF); src_n.push_back(W'($urandom_range(0, 4095)));
    end
    drain(100);
    check("t4_pos_rail", $signed(bus1.signal), 2047);

    // T5: lone primary sample times out; clear; then a set/clear collision
    src_s.push_back(12'h555);
    gate_s = 1; gate_n = 0;
    repeat (64) tick();
    check("t5_pre_flush", bus0.desync, 0);
    tick();
    check("t5_flush", bus0.desync, 1);
    clr_desync = 1;
    tick();
    clr_desync = 0;
    check("t5_cleared", bus0.desync, 0);
    src_s.push_back(12'h123); src_n.push_back(12'h456);
    drain(10);
    check("t5_pair_sig", $signed(bus0.signal), -1757);
    check("t5_pair_nos", $signed(bus0.noise), -938);
    src_n.push_back(12'h321);
    gate_s = 0; gate_n = 1;
    clr_desync = 1;
    repeat (65) tick();
    clr_desync = 0;
    check("t5_set_wins", bus0.desync, 1);

    // T6: reset with samples buffered
    for (int i = 0; i < 3; i++) src_s.push_back(W'($urandom_range(0, 4095)));
    gate_s = 1; gate_n = 0;
    repeat (3) tick();
    do_reset(2);
    tick();
    check("t6_valid", bus0.out_valid, 0);
    check("t6_signal", $signed(bus0.signal), 0);
    check("t6_noise", $signed(bus0.noise), 0);
    check("t6_ready", bus0.sig_ready, 1);
    src_s.push_back(12'hC00); src_n.push_back(12'h400);
    drain(10);
    check("t6_fresh_sig", $signed(bus0.signal), 1024);
    check("t6_fresh_nos", $signed(bus0.noise), -1024);

    // random traffic with gaps and occasional clears
    for (int i = 0; i < 400; i++) begin
      if (src_s.size() < 2 && $urandom_range(0, 1) == 1) src_s.push_back(W'($urandom_range(0, 4095)));
      if (src_n.size() < 2 && $urandom_range(0, 1) == 1) src_n.push_back(W'($urandom_range(0, 4095)));
      gate_s = ($urandom_range(0, 3) != 0);
      gate_n = ($urandom_range(0, 3) != 0);
      clr_desync = ($urandom_range(0, 31) == 0);
      tick();
    end
    clr_desync = 0;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
